// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx
// PS/2 keyboard frame receiver and scancode framer for the ZX81 core.
// Samples the raw PS/2 pins, filters the clock, validates 11-bit
// device-to-host frames and folds the E0 (extended) / F0 (release)
// prefixes into one toggle-strobed key event word.
//
// Optional feature macro: PS2_PARITY_CHECK_EN
//   defined   -> frames must carry odd parity (data + parity bit); a
//                parity failure pulses err and emits no event.
//   undefined -> the parity bit is clocked past and ignored.
//
// Ports:
//   clk       in   system clock (CPU clock, 3.25 MHz)
//   reset     in   synchronous active-low reset
//   ps2_clk   in   raw PS/2 clock pin (asynchronous)
//   ps2_data  in   raw PS/2 data pin (asynchronous)
//   ps2_key   out  [10] event toggle, [9] pressed, [8] extended, [7:0] scancode
//   err       out  one-cycle pulse on framing, parity or timeout error
module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 6500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  logic [1:0]    clk_sync_q;
  logic [1:0]    dat_sync_q;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          fclk_q, fclk_d;
  state_e        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [TW-1:0] tout_q, tout_d;
  logic          ext_q, ext_d;
  logic          rel_q, rel_d;
  logic [10:0]   key_q, key_d;
  logic          err_q, err_d;
`ifdef PS2_PARITY_CHECK_EN
  logic          par_q, par_d;
`endif

  logic fall;
  logic data_bit;
  logic frame_ok;

  assign data_bit = dat_sync_q[1];

  // Clock glitch filter: the filtered clock follows the synchronised pin
  // only once FILTER_LEN consecutive samples disagree with it.
  always_comb begin
    filt_cnt_d = filt_cnt_q;
    fclk_d     = fclk_q;
    if (clk_sync_q[1] == fclk_q) begin
      filt_cnt_d = '0;
    end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
      fclk_d     = clk_sync_q[1];
      filt_cnt_d = '0;
    end else begin
      filt_cnt_d = filt_cnt_q + 1'b1;
    end
  end

  // Falling edge of the filtered clock, flagged in the cycle it happens.
  assign fall = fclk_q & ~fclk_d;

  // Frame FSM, timeout and prefix folding.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tout_d    = tout_q;
    ext_d     = ext_q;
    rel_d     = rel_q;
    key_d     = key_q;
    err_d     = 1'b0;
    frame_ok  = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_d     = par_q;
`endif

    if (fall) begin
      // A clock edge always takes priority over an expiring timeout.
      tout_d = '0;
      unique case (state_q)
        S_IDLE: begin
          if (!data_bit) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end else begin
            err_d = 1'b1;
            ext_d = 1'b0;
            rel_d = 1'b0;
          end
        end
        S_DATA: begin
          shift_d   = {data_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          par_d = data_bit;
`endif
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
`ifdef PS2_PARITY_CHECK_EN
          frame_ok = data_bit & (^{shift_q, par_q});
`else
          frame_ok = data_bit;
`endif
          if (!frame_ok) begin
            err_d = 1'b1;
            ext_d = 1'b0;
            rel_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q == S_IDLE) begin
      tout_d = '0;
    end else if (tout_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d = S_IDLE;
      tout_d  = '0;
      err_d   = 1'b1;
      ext_d   = 1'b0;
      rel_d   = 1'b0;
    end else begin
      tout_d = tout_q + 1'b1;
    end

    if (frame_ok) begin
      unique case (shift_q)
        8'hE0: ext_d = 1'b1;
        8'hF0: rel_d = 1'b1;
        8'hE1: ;
        default: begin
          // AA (BAT pass) and FA (ACK) are only key codes when prefixed.
          if (!((shift_q == 8'hAA || shift_q == 8'hFA) && !ext_q && !rel_q)) begin
            key_d = {~key_q[10], ~rel_q, ext_q, shift_q};
            ext_d = 1'b0;
            rel_d = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_cnt_q <= '0;
      fclk_q     <= 1'b1;
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      tout_q     <= '0;
      ext_q      <= 1'b0;
      rel_q      <= 1'b0;
      key_q      <= '0;
      err_q      <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_q      <= 1'b0;
`endif
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
      filt_cnt_q <= filt_cnt_d;
      fclk_q     <= fclk_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      tout_q     <= tout_d;
      ext_q      <= ext_d;
      rel_q      <= rel_d;
      key_q      <= key_d;
      err_q      <= err_d;
`ifdef PS2_PARITY_CHECK_EN
      par_q      <= par_d;
`endif
    end
  end

  assign ps2_key = key_q;
  assign err     = err_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
module tb_ps2_keyboard_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        err;

  ps2_keyboard_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(6500)) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ps2_key  (ps2_key),
    .err      (err)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [10:0] exp_q[$];
  logic [10:0] mon_exp;
  logic [10:0] prev_key = '0;
  logic        prev_err = 1'b0;
  int          err_pulses = 0;
  int          err_cycles = 0;
  logic        exp_tog = 1'b0;
  logic [9:0]  last_low = '0;

  typedef struct {
    logic [7:0] data;
    bit         good_par;
    bit         good_stop;
    bit         evt;
    int         errs;
    logic [9:0] key;
  } vec_t;

  vec_t vecs[14];

  // Output monitor: pops the scoreboard whenever the event word changes.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      prev_key = ps2_key;
      prev_err = err;
    end else begin
      if (ps2_key !== prev_key) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event got %h required no change", ps2_key);
        end else begin
          mon_exp = exp_q.pop_front();
          if (ps2_key !== mon_exp) begin
            fails++;
            $display("FAIL event_word got %h required %h", ps2_key, mon_exp);
          end else begin
            $display("[TB] event %h", ps2_key);
          end
        end
      end
      if (err === 1'b1) begin
        err_cycles++;
        if (prev_err !== 1'b1) err_pulses++;
      end
      prev_key = ps2_key;
      prev_err = err;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    cycles(20);
    ps2_clk = 1'b0;
    cycles(40);
    ps2_clk = 1'b1;
    cycles(20);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) send_bit(bits[i]);
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit gp, input bit gs);
    logic [10:0] bits;
    bits = {gs ? 1'b1 : 1'b0, gp ? ~(^d) : (^d), d, 1'b0};
    send_bits(bits, 11);
  endtask

  task automatic expect_key(input logic [9:0] low);
    exp_tog  = ~exp_tog;
    last_low = low;
    exp_q.push_back({exp_tog, low});
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s got %0h required %0h", name, got, req);
    end
  endtask

  task automatic check_idle_word(input string name);
    check(name, {21'd0, ps2_key}, {21'd0, exp_tog, last_low});
  endtask

  initial begin
    int e0;

    vecs[0]  = '{8'hAA, 1, 1, 0, 0, 10'h000};
    vecs[1]  = '{8'h1C, 1, 1, 1, 0, {2'b10, 8'h1C}};
    vecs[2]  = '{8'hE0, 1, 1, 0, 0, 10'h000};
    vecs[3]  = '{8'hF0, 1, 1, 0, 0, 10'h000};
    vecs[4]  = '{8'h75, 1, 1, 1, 0, {2'b01, 8'h75}};
    vecs[5]  = '{8'hFA, 1, 1, 0, 0, 10'h000};
    vecs[6]  = '{8'hE1, 1, 1, 0, 0, 10'h000};
    vecs[7]  = '{8'h14, 1, 1, 1, 0, {2'b10, 8'h14}};
    vecs[8]  = '{8'hE0, 1, 1, 0, 0, 10'h000};
    vecs[9]  = '{8'h33, 1, 0, 0, 1, 10'h000};
    vecs[10] = '{8'h75, 1, 1, 1, 0, {2'b10, 8'h75}};
    vecs[11] = '{8'hF0, 1, 1, 0, 0, 10'h000};
    vecs[12] = '{8'hAA, 1, 1, 1, 0, {2'b00, 8'hAA}};
`ifdef PS2_PARITY_CHECK_EN
    vecs[13] = '{8'h1C, 0, 1, 0, 1, 10'h000};
`else
    vecs[13] = '{8'h1C, 0, 1, 1, 0, {2'b10, 8'h1C}};
`endif

    // Reset state
    cycles(4);
    reset = 1'b1;
    cycles(3);
    check("reset_key", {21'd0, ps2_key}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);

    // Table-driven frames
    for (int i = 0; i < 14; i++) begin
      e0 = err_pulses;
      if (vecs[i].evt) expect_key(vecs[i].key);
      send_frame(vecs[i].data, vecs[i].good_par, vecs[i].good_stop);
      cycles(30);
      $display("[TB] vec %0d byte %h key %h err_pulses %0d", i, vecs[i].data, ps2_key, err_pulses - e0);
      check($sformatf("vec%0d_err", i), err_pulses - e0, vecs[i].errs);
      check($sformatf("vec%0d_pending", i), exp_q.size(), 0);
      check_idle_word($sformatf("vec%0d_word", i));
    end

    // Glitch on the clock pin shorter than the filter
    e0 = err_pulses;
    @(negedge clk);
    ps2_clk = 1'b0;
    cycles(5);
    ps2_clk = 1'b1;
    cycles(50);
    $display("[TB] glitch key %h", ps2_key);
    check("glitch_err", err_pulses - e0, 0);
    check_idle_word("glitch_word");
    expect_key({2'b10, 8'h1C});
    send_frame(8'h1C, 1, 1);
    cycles(30);
    check("glitch_next_err", err_pulses - e0, 0);
    check("glitch_next_pending", exp_q.size(), 0);

    // Timeout: start bit plus three data bits, then silence
    e0 = err_pulses;
    send_bits({3'b111, 8'h5A}, 4);
    cycles(6300);
    check("timeout_early", err_pulses - e0, 0);
    cycles(400);
    $display("[TB] timeout err_pulses %0d", err_pulses - e0);
    check("timeout_err", err_pulses - e0, 1);
    check_idle_word("timeout_word");
    e0 = err_pulses;
    expect_key({2'b10, 8'h29});
    send_frame(8'h29, 1, 1);
    cycles(30);
    check("after_timeout_err", err_pulses - e0, 0);
    check("after_timeout_pending", exp_q.size(), 0);

    // Reset in the middle of a frame
    send_bits({3'b111, 8'h3C}, 5);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    $display("[TB] reset mid-frame key %h err %b", ps2_key, err);
    check("midreset_key", {21'd0, ps2_key}, 32'd0);
    check("midreset_err", {31'd0, err}, 32'd0);
    exp_tog  = 1'b0;
    last_low = '0;
    e0 = err_pulses;
    expect_key({2'b10, 8'h16});
    send_frame(8'h16, 1, 1);
    cycles(30);
    check("after_reset_err", err_pulses - e0, 0);
    check("after_reset_pending", exp_q.size(), 0);
    check("after_reset_word", {21'd0, ps2_key}, {21'd0, 11'h616});

    // Every error pulse lasted exactly one cycle
    check("err_width", err_cycles, err_pulses);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
